// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one outstanding instruction-memory read at a time
// and queues the responses in a small FIFO for the decoder.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module fetch_unit #(
    parameter int BUF_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [`DATA_WIDTH-1:0] pc,
    input  logic                   flush,
    output logic                   imem_req,
    output logic [`DATA_WIDTH-1:0] imem_addr,
    input  logic                   imem_ack,
    input  logic [`DATA_WIDTH-1:0] imem_data,
    output logic [`DATA_WIDTH-1:0] inst,
    output logic [`DATA_WIDTH-1:0] inst_pc,
    output logic                   inst_valid,
    input  logic                   inst_ready
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int DW    = `DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t             state_r;
    logic [DW-1:0]      data_mem_r [BUF_DEPTH];
    logic [DW-1:0]      addr_mem_r [BUF_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               push_s;
    logic               pop_s;
    logic               issue_s;

    // Flush overrides push, pop and issue; issue only from IDLE so at most one
    // request is outstanding and the buffer always has room for its response.
    always_comb begin
        push_s  = 1'b0;
        pop_s   = 1'b0;
        issue_s = 1'b0;
        if (!flush) begin
            push_s  = (state_r == WAIT) && imem_ack;
            pop_s   = (count_r != {CNT_W{1'b0}}) && inst_ready;
            issue_s = (state_r == IDLE) && (count_r < CNT_W'(BUF_DEPTH));
        end else begin
            push_s  = 1'b0;
            pop_s   = 1'b0;
            issue_s = 1'b0;
        end
    end

    // Request FSM; imem_req and imem_addr are registered and only move on issue/retire.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            imem_req  <= 1'b0;
            imem_addr <= {DW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (issue_s) begin
                        state_r   <= WAIT;
                        imem_req  <= 1'b1;
                        imem_addr <= pc;
                    end else begin
                        imem_req  <= 1'b0;
                    end
                end
                WAIT: begin
                    if (imem_ack) begin
                        state_r  <= IDLE;
                        imem_req <= 1'b0;
                    end else if (flush) begin
                        state_r  <= DROP;
                    end else begin
                        state_r  <= WAIT;
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        state_r  <= IDLE;
                        imem_req <= 1'b0;
                    end else begin
                        state_r  <= DROP;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    // Instruction FIFO; storage is cleared on reset so inst/inst_pc read back zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < BUF_DEPTH; i++) begin
                data_mem_r[i] <= {DW{1'b0}};
                addr_mem_r[i] <= {DW{1'b0}};
            end
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                data_mem_r[wr_ptr_r] <= imem_data;
                addr_mem_r[wr_ptr_r] <= imem_addr;
                wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign inst       = data_mem_r[rd_ptr_r];
    assign inst_pc    = addr_mem_r[rd_ptr_r];
    assign inst_valid = (count_r != {CNT_W{1'b0}});

endmodule
